// File: rtl/fifo_wr_ctrl.sv
// Write-domain half of the async FIFO: pointer/Gray generation, read-pointer
// synchroniser, and full / almost-full / level / sticky-overflow status.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_inc,
  input  logic                  w_ovf_clr,
  input  logic [ADDR_WIDTH:0]   r_ptr,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_ovf
);
  localparam int PW = ADDR_WIDTH + 1;
  // Full when the write Gray pointer equals the read one with its top two bits inverted
  localparam logic [PW-1:0] FULL_XOR = {2'b11, {(PW-2){1'b0}}};
  localparam logic [PW-1:0] AF_LVL   = PW'(AF_THRESH);

  logic [PW-1:0] w_bin, w_bin_nxt;
  logic [PW-1:0] rq1_rptr, rq2_rptr, r_bin;

  assign w_bin_nxt = w_bin + PW'(1);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_bin    <= '0;
      w_ptr    <= '0;
      rq1_rptr <= '0;
      rq2_rptr <= '0;
      w_ovf    <= 1'b0;
    end else begin
      rq1_rptr <= r_ptr;
      rq2_rptr <= rq1_rptr;
      // Gray pointer is registered from the next binary value so it never glitches
      if (w_en) begin
        w_bin <= w_bin_nxt;
        w_ptr <= w_bin_nxt ^ (w_bin_nxt >> 1);
      end
      if (w_inc && w_full)
        w_ovf <= 1'b1;
      else if (w_ovf_clr)
        w_ovf <= 1'b0;
    end
  end

  // Gray to binary: each bit is the XOR of itself and every bit above it
  always_comb begin
    r_bin = '0;
    for (int i = 0; i < PW; i++)
      r_bin[i] = ^(rq2_rptr >> i);
  end

  assign w_level       = w_bin - r_bin;
  assign w_full        = (w_ptr == (rq2_rptr ^ FULL_XOR));
  assign w_almost_full = (w_level >= AF_LVL);
  assign w_addr        = w_bin[ADDR_WIDTH-1:0];
  // Strobe is held off while in reset so the memory never sees a stray write
  assign w_en          = w_inc & ~w_full & w_rst_n;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: the driver queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_fifo_wr_ctrl;
  logic       w_clk = 1'b0;
  logic       w_rst_n;
  logic       w_inc;
  logic       w_ovf_clr;
  logic [3:0] r_ptr;
  logic       w_en;
  logic [2:0] w_addr;
  logic [3:0] w_ptr;
  logic       w_full;
  logic       w_almost_full;
  logic [3:0] w_level;
  logic       w_ovf;

  fifo_wr_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(6)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_inc(w_inc), .w_ovf_clr(w_ovf_clr),
    .r_ptr(r_ptr), .w_en(w_en), .w_addr(w_addr), .w_ptr(w_ptr),
    .w_full(w_full), .w_almost_full(w_almost_full), .w_level(w_level), .w_ovf(w_ovf)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic       en;
    logic [2:0] addr;
    logic [3:0] ptr;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } obs_t;

  obs_t  exp_q[$];
  string nm_q[$];
  int    errors = 0;
  int    checks = 0;

  // Expected Gray pointer after each of the 8 fill writes
  logic [3:0] fill_tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0111, 4'b0101, 4'b0100, 4'b1100};

  // Reference state
  logic [3:0] m_bin, m_rq1, m_rq2;
  logic       m_ovf, m_rst;

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic obs_t model_obs(input logic inc);
    obs_t o;
    o.lvl  = m_bin - g2b(m_rq2);
    o.full = (o.lvl == 4'd8);
    o.af   = (o.lvl >= 4'd6);
    o.ptr  = b2g(m_bin);
    o.addr = m_bin[2:0];
    o.en   = inc & ~o.full & m_rst;
    o.ovf  = m_ovf;
    return o;
  endfunction

  // One cycle: drive inputs just after the edge, queue what the monitor should
  // see mid-cycle, then advance the model through the following edge.
  task automatic cyc(input logic inc, input logic clr, input logic [3:0] rp,
                     input string nm, input int hp = -1);
    obs_t o;
    @(posedge w_clk); #1;
    w_inc = inc; w_ovf_clr = clr; r_ptr = rp;
    o = model_obs(inc);
    if (hp >= 0) o.ptr = 4'(hp);
    exp_q.push_back(o);
    nm_q.push_back(nm);
    if (inc && o.full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    if (o.en) m_bin = m_bin + 4'd1;
    m_rq2 = m_rq1;
    m_rq1 = rp;
  endtask

  task automatic model_clear();
    m_bin = '0; m_rq1 = '0; m_rq2 = '0; m_ovf = 1'b0;
  endtask

  // Reset asserted mid-cycle with a write still requested
  task automatic do_reset();
    @(posedge w_clk); #1;
    w_rst_n = 1'b0; w_inc = 1'b1; w_ovf_clr = 1'b0;
    m_rst = 1'b0;
    model_clear();
    exp_q.push_back(model_obs(1'b1));
    nm_q.push_back("rst_async");
    @(posedge w_clk); #1;
    w_rst_n = 1'b1; w_inc = 1'b0; r_ptr = 4'b0000;
    m_rst = 1'b1;
    exp_q.push_back(model_obs(1'b0));
    nm_q.push_back("rst_release");
  endtask

  always @(negedge w_clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = '{en:w_en, addr:w_addr, ptr:w_ptr, full:w_full, af:w_almost_full, lvl:w_level, ovf:w_ovf};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got en=%b addr=%0d ptr=%b full=%b af=%b lvl=%0d ovf=%b, want en=%b addr=%0d ptr=%b full=%b af=%b lvl=%0d ovf=%b",
                 n, a.en, a.addr, a.ptr, a.full, a.af, a.lvl, a.ovf,
                 e.en, e.addr, e.ptr, e.full, e.af, e.lvl, e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rb;
    w_rst_n = 1'b0; w_inc = 1'b0; w_ovf_clr = 1'b0; r_ptr = '0;
    m_rst = 1'b0;
    model_clear();
    repeat (2) @(posedge w_clk);
    #1 w_rst_n = 1'b1;
    m_rst = 1'b1;

    cyc(1'b0, 1'b0, 4'b0000, "rst_state", 0);
    repeat (5) cyc(1'b1, 1'b0, 4'b0000, "pre_fill");
    do_reset();
    repeat (2) cyc(1'b0, 1'b0, 4'b0000, "post_rst");

    // Fill: eight back-to-back writes against an idle reader
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 4'b0000, "fill", (i == 0) ? 0 : int'(fill_tbl[i-1]));

    // Writes while full are dropped and set the sticky flag
    repeat (3) cyc(1'b1, 1'b0, 4'b0000, "ovf_hold", 12);
    cyc(1'b0, 1'b1, 4'b0000, "ovf_clr", 12);
    cyc(1'b1, 1'b1, 4'b0000, "ovf_set_wins", 12);
    cyc(1'b0, 1'b0, 4'b0000, "ovf_kept", 12);
    cyc(1'b0, 1'b1, 4'b0000, "ovf_clr2", 12);

    // Reader advances by one; full drops only after two synchroniser stages
    repeat (3) cyc(1'b0, 1'b0, 4'b0001, "rd_release");

    // Reader jumps to bin 6, then streams while writer writes across the wrap
    repeat (3) cyc(1'b0, 1'b0, b2g(4'd6), "rd_catchup");
    rb = 4'd7;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, b2g(rb), "wrap");
      rb = rb + 4'd1;
    end
    cyc(1'b0, 1'b0, b2g(rb), "wrap_tail");

    repeat (3) @(negedge w_clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-domain control for the team's asynchronous FIFO. It is the stage upstream of the read-side controller. It does the following:
- converts write requests into memory write enables and addresses;
- maintains the binary and Gray write pointers;
- synchronises the read-side Gray pointer into the write clock domain;
- derives full, almost-full, fill level and a sticky overflow flag.

Its registered Gray pointer `w_ptr` is the value the read side synchronises as its write pointer.

## Interface
- `ADDR_WIDTH`, default 3: memory address width. Depth is 2^ADDR_WIDTH and the pointer width is ADDR_WIDTH+1.
- `AF_THRESH`, default 6: `w_almost_full` asserts when the fill level is at or above this value. Legal range is 1..DEPTH.
- `w_clk` input, 1 bit: write clock.
- `w_rst_n` input, 1 bit: asynchronous active-low reset for the write domain.
- `w_inc` input, 1 bit: write request for this cycle.
- `w_ovf_clr` input, 1 bit: clears `w_ovf`.
- `r_ptr` input, ADDR_WIDTH+1 bits: Gray read pointer from the read clock domain. It is asynchronous to `w_clk`.
- `w_en` output, 1 bit: memory write strobe, equal to `w_inc && !w_full`.
- `w_addr` output, ADDR_WIDTH bits: memory write address, equal to the low bits of the binary pointer.
- `w_ptr` output, ADDR_WIDTH+1 bits: registered Gray write pointer.
- `w_full` output, 1 bit: FIFO full.
- `w_almost_full` output, 1 bit: fill level is at or above AF_THRESH.
- `w_level` output, ADDR_WIDTH+1 bits: fill level as seen from the write side, range 0..DEPTH.
- `w_ovf` output, 1 bit: sticky flag meaning a write was attempted while full.

## Operation
- **Registers.** The block holds:
  - `w_bin`, the binary pointer, ADDR_WIDTH+1 bits;
  - `w_ptr`, the Gray pointer, ADDR_WIDTH+1 bits;
  - `rq1_rptr` and `rq2_rptr`, two-flop synchroniser stages for `r_ptr`;
  - `w_ovf`.
- **Pointer update.** When `w_en` is 1 on a clock edge:
  - `w_bin` becomes `w_bin + 1`, wrapping modulo 2^(ADDR_WIDTH+1);
  - `w_ptr` becomes `(w_bin+1) ^ ((w_bin+1) >> 1)`.
  - `w_ptr` is loaded directly from the next binary value. It must never be a combinational decode of `w_bin`, because glitches would cross the clock domain.
- **Synchroniser.** `rq1_rptr` takes `r_ptr` on each clock edge and `rq2_rptr` takes `rq1_rptr`. Only `rq2_rptr` is used in any logic.
- **Full.** `w_full = (w_ptr == {~rq2_rptr[MSB:MSB-1], rq2_rptr[MSB-2:0]})`.
  - This is combinational from flops only, with no path from any input.
  - Full is pessimistic. It clears only after a read-pointer advance has passed through the synchroniser.
- **Level.**
  - `w_level = w_bin - gray2bin(rq2_rptr)`, computed modulo 2^(ADDR_WIDTH+1).
  - `gray2bin` is a prefix XOR from the MSB down.
  - It is combinational from flops.
  - `w_full` is 1 exactly when `w_level == DEPTH`.
- **Almost full.** `w_almost_full = (w_level >= AF_THRESH)`.
- **Overflow.**
  - If `w_inc && w_full` on an edge, `w_ovf` becomes 1.
  - Otherwise, if `w_ovf_clr` is 1, `w_ovf` becomes 0.
  - Set wins over clear when both occur on the same edge.
- **Write while full.** The write is dropped: `w_en` is 0 and the pointers hold.
- **Reset.** While `w_rst_n` is 0, all registers are asynchronously cleared. The outputs are then:
  - `w_bin`, `w_ptr`, `w_addr`, `w_level`, `rq1_rptr`, `rq2_rptr` = 0;
  - `w_full`, `w_almost_full`, `w_ovf`, `w_en` = 0.
  - Reset mid-operation discards all state. The read domain must be reset in the same window.

## Timing
- **Write to address.** A write accepted at edge N gives new `w_addr`, `w_ptr` and `w_level` immediately after edge N.
- **Full assertion.** Full asserts in the same cycle the DEPTH-th unread write is registered. The next `w_inc` is blocked without any extra cycle.
- **Read-pointer latency.** A change on `r_ptr` before edge N is visible in `rq2_rptr`, `w_level` and `w_full` after edge N+1, i.e. 2 cycles.
- **Simultaneous events.** A simultaneous write and synchronised read-pointer advance moves `w_level` by +1-1 = 0. Full is evaluated on the resulting registers.
- **Wrap-around.** At the wrap `w_bin` goes from 2^(ADDR_WIDTH+1)-1 to 0, and `w_ptr` goes from 1000 to 0000 (ADDR_WIDTH=3). Level arithmetic stays correct across the wrap.
- **Handshake.** `w_en` is combinational from `w_inc` and the registered full. The upstream source may hold `w_inc` high continuously.

## Test plan
- **Reset.** Assert `w_rst_n`=0 mid-stream with `w_bin`=5.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Required: after release with `r_ptr`=0, `w_level`=0 and `w_full`=0.
- **Fill.** With `r_ptr`=0000, apply 8 consecutive `w_inc`.
  - Required: `w_ptr` sequence 0001,0011,0010,0110,0111,0101,0100,1100.
  - Required: `w_almost_full` rises after the 6th edge.
  - Required: after the 8th edge, `w_full`=1, `w_level`=8 and `w_addr`=0.
- **Overflow.** From the full state, hold `w_inc` for 3 cycles.
  - Required: `w_en`=0 throughout and `w_ptr` stays 1100.
  - Required: `w_ovf`=1 after the first edge.
  - Required: pulsing `w_ovf_clr` with `w_inc`=0 clears it, and pulsing it with `w_inc`=1 does not.
- **Read release.** From the full state, change `r_ptr` to 0001.
  - Required: `w_full` stays 1 for one edge.
  - Required: after the second edge, `w_full`=0 and `w_level`=7.
- **Wrap.** Drive 20 writes while the model advances `r_ptr` in Gray, lagging 2 entries.
  - Required: `w_full` never asserts.
  - Required: `w_ptr` passes 1000 to 0000.
  - Required: `w_level` matches the model every cycle.
